// File: rtl/vga_frame_monitor_if.sv
// Signal bundle between the VGA display path (master) and the frame monitor (slave).
// Sync/pixel lines flow to the monitor. Measurements and status flow back.
interface vga_frame_monitor_if;
  logic        hsync_in;
  logic        vsync_in;
  logic        pixel_in;
  logic [10:0] h_period;
  logic [9:0]  v_lines;
  logic [18:0] lit_count;
  logic [9:0]  x_pos;
  logic [9:0]  y_pos;
  logic        in_active;
  logic        frame_done;
  logic        locked;
  logic        sync_error;

  modport master (
    output hsync_in, vsync_in, pixel_in,
    input  h_period, v_lines, lit_count, x_pos, y_pos, in_active,
           frame_done, locked, sync_error
  );

  modport slave (
    input  hsync_in, vsync_in, pixel_in,
    output h_period, v_lines, lit_count, x_pos, y_pos, in_active,
           frame_done, locked, sync_error
  );
endinterface

// File: rtl/vga_frame_monitor.sv
// Receive-side VGA timing monitor: measures line period, line count and lit pixels per frame
// and tracks lock.
//   state     | meaning
//   S_SEARCH  | no frame reference yet (after reset or hsync timeout)
//   S_ACQUIRE | closing frames, counting consecutive matching (h_period, v_lines) pairs
//   S_LOCKED  | timing stable; a mismatching frame or timeout raises sync_error
module vga_frame_monitor #(
  parameter int H_START         = 184,
  parameter int V_START         = 19,
  parameter int H_VISIBLE       = 640,
  parameter int V_VISIBLE       = 480,
  parameter bit SYNC_ACTIVE_LOW = 1'b1,
  parameter int LOCK_FRAMES     = 2,
  parameter int TIMEOUT         = 4095
) (
  input logic                clk,
  input logic                reset,
  vga_frame_monitor_if.slave vif
);

  localparam int TW = $clog2(TIMEOUT + 2);
  localparam int MW = (LOCK_FRAMES > 1) ? $clog2(LOCK_FRAMES) : 1;

  localparam logic [11:0]   H_LO       = 12'(H_START);
  localparam logic [11:0]   H_HI       = 12'(H_START + H_VISIBLE);
  localparam logic [10:0]   V_LO       = 11'(V_START);
  localparam logic [10:0]   V_HI       = 11'(V_START + V_VISIBLE);
  localparam logic [9:0]    H_OFF      = 10'(H_START);
  localparam logic [9:0]    V_OFF      = 10'(V_START);
  localparam logic [TW-1:0] TO_LIM     = TW'(TIMEOUT);
  localparam logic [TW-1:0] TO_SAT     = TW'(TIMEOUT + 1);
  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_FRAMES - 1);

  typedef enum logic [1:0] {
    S_SEARCH  = 2'd0,
    S_ACQUIRE = 2'd1,
    S_LOCKED  = 2'd2
  } state_t;

  state_t          state_q;
  logic [MW-1:0]   match_q;

  logic            hs_q, vs_q, px_q;
  logic            hs_prev_q, vs_prev_q;
  logic [10:0]     h_cnt_q, h_cnt_d;
  logic [9:0]      v_cnt_q, v_cnt_d;
  logic [10:0]     cand_q, cand_d;
  logic [18:0]     acc_q, acc_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;

  logic [10:0]     h_period_q;
  logic [9:0]      v_lines_q;
  logic [18:0]     lit_q;
  logic            frame_done_q;
  logic            locked_q;
  logic            sync_err_q;

  logic            hs_edge, vs_edge;
  logic [10:0]     h_inc;
  logic [9:0]      v_inc;
  logic            in_act;
  logic            timeout;
  logic            pair_match;

  assign hs_edge = hs_q & ~hs_prev_q;
  assign vs_edge = vs_q & ~vs_prev_q;

  assign h_inc = (h_cnt_q == 11'h7FF) ? h_cnt_q : h_cnt_q + 11'd1;
  assign v_inc = (v_cnt_q == 10'h3FF) ? v_cnt_q : v_cnt_q + 10'd1;

  assign in_act = ({1'b0, h_cnt_q} >= H_LO) && ({1'b0, h_cnt_q} < H_HI) &&
                  ({1'b0, v_cnt_q} >= V_LO) && ({1'b0, v_cnt_q} < V_HI);

  // to_cnt_q counts clocks since the last hsync edge; past TIMEOUT the reference is lost
  assign timeout = !hs_edge && (to_cnt_q >= TO_LIM);

  always_comb begin
    h_cnt_d  = hs_edge ? 11'd0 : h_inc;
    cand_d   = hs_edge ? h_inc : cand_q;
    v_cnt_d  = v_cnt_q;
    if (vs_edge) begin
      v_cnt_d = 10'd0;
    end else if (hs_edge) begin
      v_cnt_d = v_inc;
    end
    acc_d = acc_q;
    if (vs_edge) begin
      acc_d = 19'd0;
    end else if (in_act && px_q && (acc_q != 19'h7FFFF)) begin
      acc_d = acc_q + 19'd1;
    end
    to_cnt_d = to_cnt_q;
    if (hs_edge) begin
      to_cnt_d = TW'(1);
    end else if (to_cnt_q != TO_SAT) begin
      to_cnt_d = to_cnt_q + TW'(1);
    end
  end

  // The frame-closing pair uses the forwarded candidate so a coincident hsync edge counts
  assign pair_match = (cand_d == h_period_q) && (v_inc == v_lines_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      px_q      <= 1'b0;
      hs_prev_q <= 1'b0;
      vs_prev_q <= 1'b0;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      cand_q    <= '0;
      acc_q     <= '0;
      to_cnt_q  <= '0;
    end else begin
      hs_q      <= vif.hsync_in ^ SYNC_ACTIVE_LOW;
      vs_q      <= vif.vsync_in ^ SYNC_ACTIVE_LOW;
      px_q      <= vif.pixel_in;
      hs_prev_q <= hs_q;
      vs_prev_q <= vs_q;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      cand_q    <= cand_d;
      acc_q     <= acc_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_SEARCH;
      match_q      <= '0;
      h_period_q   <= '0;
      v_lines_q    <= '0;
      lit_q        <= '0;
      frame_done_q <= 1'b0;
      locked_q     <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
      if (timeout) begin
        state_q    <= S_SEARCH;
        match_q    <= '0;
        locked_q   <= 1'b0;
        sync_err_q <= (state_q == S_LOCKED);
      end else if (vs_edge) begin
        case (state_q)
          S_SEARCH: begin
            state_q <= S_ACQUIRE;
            match_q <= '0;
          end
          S_ACQUIRE, S_LOCKED: begin
            frame_done_q <= 1'b1;
            h_period_q   <= cand_d;
            v_lines_q    <= v_inc;
            lit_q        <= acc_q;
            if (pair_match) begin
              if (state_q == S_ACQUIRE) begin
                if (match_q == MATCH_LAST) begin
                  state_q  <= S_LOCKED;
                  locked_q <= 1'b1;
                end else begin
                  match_q <= match_q + MW'(1);
                end
              end
            end else begin
              match_q <= '0;
              if (state_q == S_LOCKED) begin
                state_q    <= S_ACQUIRE;
                locked_q   <= 1'b0;
                sync_err_q <= 1'b1;
              end
            end
          end
          default: begin
            state_q  <= S_SEARCH;
            match_q  <= '0;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign vif.h_period   = h_period_q;
  assign vif.v_lines    = v_lines_q;
  assign vif.lit_count  = lit_q;
  assign vif.in_active  = in_act;
  assign vif.x_pos      = in_act ? (h_cnt_q[9:0] - H_OFF) : 10'd0;
  assign vif.y_pos      = in_act ? (v_cnt_q - V_OFF) : 10'd0;
  assign vif.frame_done = frame_done_q;
  assign vif.locked     = locked_q;
  assign vif.sync_error = sync_err_q;

endmodule
